// File: rtl/fifo_ctrl.sv
// Pointer/flag controller that turns a dual-address register RAM into a synchronous FIFO.
// Drives RAM read/write strobes and addresses; tracks occupancy, threshold and sticky error flags.
module fifo_ctrl #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PTR_W    = 3,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic              write_signal,
  output logic [ADDR_W-1:0] write_addr,
  output logic              read_signal,
  output logic [ADDR_W-1:0] read_addr,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [PTR_W:0]    count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W:0] One   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0] AfLvl = (PTR_W + 1)'(AF_LEVEL);
  localparam logic [PTR_W:0] AeLvl = (PTR_W + 1)'(AE_LEVEL);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count_q, count_d;
  logic           rd_valid_q, rd_valid_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;

  logic ptr_full, ptr_empty;
  logic push, pop;

  // Flags come from registered pointers only; requests never reach them combinationally.
  always_comb begin
    ptr_empty = (wr_ptr_q == rd_ptr_q);
    ptr_full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  end

  // Acceptance is judged on the pre-edge state: no fall-through on empty, no write on full.
  always_comb begin
    push = wr_req & ~ptr_full & ~flush;
    pop  = rd_req & ~ptr_empty & ~flush;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = pop;
    overflow_d  = overflow_q | (wr_req & ptr_full & ~flush);
    underflow_d = underflow_q | (rd_req & ptr_empty & ~flush);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + One;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + One;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + One;
        2'b01:   count_d = count_q - One;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    write_signal = push;
    read_signal  = pop;
    write_addr   = ADDR_W'(wr_ptr_q[PTR_W-1:0]);
    read_addr    = ADDR_W'(rd_ptr_q[PTR_W-1:0]);
    rd_valid     = rd_valid_q;
    full         = ptr_full;
    empty        = ptr_empty;
    almost_full  = (count_q >= AfLvl);
    almost_empty = (count_q <= AeLvl);
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with a behavioural 16x8 RAM; directed push/pop/flush vectors.
module tb_fifo_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, flush, wr_req, rd_req;
  logic       write_signal, read_signal, rd_valid;
  logic [3:0] write_addr, read_addr;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  logic [7:0] data_in, ram_dout;
  logic [7:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side model state.
  int   m_q[$];
  int   exp_q[$];
  int   m_wr = 0;
  int   m_rd = 0;
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;

  fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .write_signal (write_signal),
    .write_addr   (write_addr),
    .read_signal  (read_signal),
    .read_addr    (read_addr),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_signal) mem[write_addr] <= data_in;
    if (read_signal) ram_dout <= mem[read_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a pending expected word must show rd_valid and that word.
  always @(negedge clk) begin
    if (rd_valid === 1'b1 || exp_q.size() != 0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_valid_unexpected: got 1 expected 0 at %0t", $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (rd_valid !== 1'b1 || ram_dout !== 8'(e)) begin
          n_fail++;
          $display("FAIL rd_data: got valid=%b data=%0h expected valid=1 data=%0h at %0t",
                   rd_valid, ram_dout, e, $time);
        end
      end
    end
  end

  task automatic check_flags();
    int c;
    c = m_q.size();
    check("count", 32'(count), 32'(c));
    check("full", 32'(full), 32'(c == DEPTH));
    check("empty", 32'(empty), 32'(c == 0));
    check("almost_full", 32'(almost_full), 32'(c >= 6));
    check("almost_empty", 32'(almost_empty), 32'(c <= 2));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // Called just after a posedge; drives one cycle of requests and updates the model at the edge.
  task automatic step(input logic wr, input logic rd, input logic fl, input logic [7:0] din);
    logic exp_push, exp_pop;
    wr_req  = wr;
    rd_req  = rd;
    flush   = fl;
    data_in = din;
    #1;
    exp_push = wr & ~fl & (m_q.size() != DEPTH);
    exp_pop  = rd & ~fl & (m_q.size() != 0);
    check("write_signal", 32'(write_signal), 32'(exp_push));
    check("read_signal", 32'(read_signal), 32'(exp_pop));
    if (exp_push) check("write_addr", 32'(write_addr), 32'(m_wr));
    if (exp_pop) check("read_addr", 32'(read_addr), 32'(m_rd));
    @(posedge clk);
    if (fl) begin
      m_q.delete();
      m_wr = 0;
      m_rd = 0;
    end else begin
      if (wr && m_q.size() == DEPTH) m_ovf = 1'b1;
      if (rd && m_q.size() == 0) m_unf = 1'b1;
      if (exp_pop) begin
        exp_q.push_back(m_q.pop_front());
        m_rd = (m_rd + 1) % DEPTH;
      end
      if (exp_push) begin
        m_q.push_back(int'(din));
        m_wr = (m_wr + 1) % DEPTH;
      end
    end
    #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    flush  = 1'b0;
    check_flags();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    flush  = 1'b0;
    @(posedge clk);
    m_q.delete();
    exp_q.delete();
    m_wr  = 0;
    m_rd  = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    rst = 1'b0;
    check("rd_valid_reset", 32'(rd_valid), 32'(0));
    check("write_signal_reset", 32'(write_signal), 32'(0));
    check("read_signal_reset", 32'(read_signal), 32'(0));
    check_flags();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    data_in = 8'h00;
    do_reset();

    // Fill: 0x11..0x88 at addresses 0..7.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h11 * (i + 1)));
    // Push while full is dropped and must not corrupt address 0.
    step(1'b1, 1'b0, 1'b0, 8'h99);
    check("mem0_after_overflow", 32'(mem[0]), 32'h11);
    // Drain, then pop while empty.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);

    // Wrap-around: write addresses run 5,6,7,0,1,2.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
    // Fill up, then push+pop while full: pop accepted, push rejected.
    step(1'b1, 1'b0, 1'b0, 8'h36);
    step(1'b1, 1'b0, 1'b0, 8'h37);
    step(1'b1, 1'b1, 1'b0, 8'h3f);
    // Down to 4, then streaming push+pop keeps the level.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 8'(8'ha0 + i));
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Push+pop on empty: push accepted, no fall-through, underflow set.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b0, 1'b0, 8'h56);
    step(1'b1, 1'b0, 1'b0, 8'h57);
    // Flush at count 3 with requests: no write, no new error flag.
    step(1'b1, 1'b1, 1'b1, 8'h58);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h61);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    // Reset clears the sticky flags too.
    step(1'b1, 1'b0, 1'b0, 8'h62);
    do_reset();
    step(1'b0, 1'b0, 1'b0, 8'h00);

    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
